quad_feeder: RTL and testbench

Transmit-side driver for the four-way interleaved 160-bit hash pipeline. It accepts whole 160-bit messages over a valid/ready interface and emits the pipeline's slotted input stream: one `phase_advance` pulse every 20 cycles and a 5-word burst on `Din` two cycles later. It also produces a result strobe and tag that line up with the first result word leaving the pipeline. It sits directly in front of the hash pipeline and is the only driver of its `Din` and `phase_advance`.

---
 rtl/quad_pkg.sv | 26 ++
 rtl/quad_feeder_fifo.sv | 63 ++++++
 rtl/quad_feeder.sv | 133 +++++++++++++
 tb/tb_quad_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared constants, types and helpers for the quad_feeder slot driver.
package quad_pkg;

  localparam int unsigned SLOT_LEN = 20;
  localparam int unsigned WORDS    = 5;
  localparam int unsigned PA_LEAD  = 2;
  localparam int unsigned PIPE_LAT = 83;
  localparam int unsigned HIST     = 4;
  localparam int unsigned MSG_W    = WORDS * 32;

  typedef logic [31:0] word_t;
  // Index WORDS-1 is the E word (message bits [159:128]), sent first.
  typedef word_t [WORDS-1:0] msg_t;
  typedef logic [4:0] slot_t;

  localparam slot_t LAST_SLOT       = slot_t'(SLOT_LEN - 1);
  localparam slot_t FIRST_WORD_SLOT = slot_t'(PA_LEAD);
  localparam slot_t LAST_WORD_SLOT  = slot_t'(PA_LEAD + WORDS - 1);
  // Slot offset at which the first result word of a slot leaves the pipeline.
  localparam slot_t RES_SLOT        = slot_t'((PA_LEAD + PIPE_LAT) % SLOT_LEN);

  function automatic word_t slot_word(input msg_t m, input logic [2:0] idx);
    return m[3'(WORDS - 1) - idx];
  endfunction

endpackage

// File: rtl/quad_feeder_fifo.sv
// Synchronous FIFO holding pending messages; ready is registered from occupancy.
module quad_feeder_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned Width = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign do_push = push_i & ready_q;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    // Next-cycle ready reflects only the registered occupancy.
    ready_d  = (count_d != CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/quad_feeder.sv
// Slot driver for the four-way interleaved hash pipeline.
// Define QUAD_FEEDER_TAG_EN to carry user tags through to res_tag_o.
module quad_feeder
  import quad_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [159:0]     in_data_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             phase_advance_o,
  output logic [31:0]      din_o,
  output logic             res_valid_o,
  output logic [TAG_W-1:0] res_tag_o
);

`ifdef QUAD_FEEDER_TAG_EN
  localparam int unsigned EntryW = TAG_W + MSG_W;
`else
  localparam int unsigned EntryW = MSG_W;
`endif

  slot_t             s_q, s_d;
  logic              slot_start;
  logic              fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;
  msg_t              slot_msg_q, slot_msg_d;
  logic              slot_vld_q, slot_vld_d;
  logic [HIST-1:0]   hist_vld_q, hist_vld_d;
  logic              pa_q;
  word_t             din_q, din_d;
  logic              res_vld_q, res_vld_d;

  quad_feeder_fifo #(
    .DEPTH (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid_i),
    .data_i  (fifo_wdata),
    .ready_o (in_ready_o),
    .pop_i   (slot_start),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty)
  );

  always_comb begin
    s_d        = (s_q == LAST_SLOT) ? '0 : s_q + 1'b1;
    slot_start = (s_d == '0);
    slot_msg_d = slot_msg_q;
    slot_vld_d = slot_vld_q;
    hist_vld_d = hist_vld_q;
    if (slot_start) begin
      slot_vld_d = ~fifo_empty;
      slot_msg_d = msg_t'(fifo_rdata[MSG_W-1:0]);
      hist_vld_d = {hist_vld_q[HIST-2:0], slot_vld_q};
    end
    din_d = '0;
    if (slot_vld_q && s_d >= FIRST_WORD_SLOT && s_d <= LAST_WORD_SLOT) begin
      din_d = slot_word(slot_msg_q, 3'(s_d - FIRST_WORD_SLOT));
    end
    // Oldest history entry is the slot issued four slots before the current one.
    res_vld_d = (s_d == RES_SLOT) && hist_vld_q[HIST-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= LAST_SLOT;
      slot_msg_q <= '0;
      slot_vld_q <= 1'b0;
      hist_vld_q <= '0;
      pa_q       <= 1'b0;
      din_q      <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      s_q        <= s_d;
      slot_msg_q <= slot_msg_d;
      slot_vld_q <= slot_vld_d;
      hist_vld_q <= hist_vld_d;
      pa_q       <= slot_start;
      din_q      <= din_d;
      res_vld_q  <= res_vld_d;
    end
  end

  assign phase_advance_o = pa_q;
  assign din_o           = din_q;
  assign res_valid_o     = res_vld_q;

`ifdef QUAD_FEEDER_TAG_EN
  logic [TAG_W-1:0]            slot_tag_q, slot_tag_d;
  logic [HIST-1:0][TAG_W-1:0]  hist_tag_q, hist_tag_d;
  logic [TAG_W-1:0]            res_tag_q, res_tag_d;

  assign fifo_wdata = {in_tag_i, in_data_i};

  always_comb begin
    slot_tag_d = slot_tag_q;
    hist_tag_d = hist_tag_q;
    if (slot_start) begin
      slot_tag_d = fifo_rdata[EntryW-1 -: TAG_W];
      hist_tag_d = {hist_tag_q[HIST-2:0], slot_tag_q};
    end
    res_tag_d = res_vld_d ? hist_tag_q[HIST-1] : res_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_tag_q <= '0;
      hist_tag_q <= '0;
      res_tag_q  <= '0;
    end else begin
      slot_tag_q <= slot_tag_d;
      hist_tag_q <= hist_tag_d;
      res_tag_q  <= res_tag_d;
    end
  end

  assign res_tag_o = res_tag_q;
`else
  logic unused_tag;

  assign fifo_wdata = in_data_i;
  assign unused_tag = ^in_tag_i;
  assign res_tag_o  = '0;
`endif

endmodule

// File: tb/tb_quad_feeder.sv
// Directed bench for quad_feeder: emission, idle, back-pressure, mixed traffic, reset.
module tb_quad_feeder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [159:0]     in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             phase_advance;
  logic [31:0]      din;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;

  quad_feeder #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .in_tag_i        (in_tag),
    .phase_advance_o (phase_advance),
    .din_o           (din),
    .res_valid_o     (res_valid),
    .res_tag_o       (res_tag)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Passive monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned since_pa = 100;
  int unsigned pa_cyc[$];
  int unsigned res_cyc[$];
  logic [7:0]  res_tags[$];
  logic [31:0] first_words[$];
  int unsigned din_nz = 0;
  int unsigned tag_nz = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (phase_advance) begin
        pa_cyc.push_back(cyc);
        since_pa = 0;
      end else begin
        since_pa++;
      end
      if (since_pa == 2) first_words.push_back(din);
      if (res_valid) begin
        res_cyc.push_back(cyc);
        res_tags.push_back(res_tag);
      end
    end
    if (din != '0) din_nz++;
    if (res_tag != '0) tag_nz++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    pa_cyc.delete();
    res_cyc.delete();
    res_tags.delete();
    first_words.delete();
    din_nz = 0;
  endtask

  task automatic wait_pa(input int unsigned max, output int unsigned n);
    n = 0;
    do begin
      step();
      n++;
    end while (!phase_advance && n <= max);
  endtask

  function automatic logic [31:0] wd(input int unsigned t, input int unsigned j);
    return 32'hC0DE_0000 + 32'(t << 8) + 32'(j);
  endfunction

  function automatic logic [159:0] mk_msg(input int unsigned t);
    return {wd(t, 0), wd(t, 1), wd(t, 2), wd(t, 3), wd(t, 4)};
  endfunction

  function automatic logic [7:0] etag(input logic [7:0] t);
`ifdef QUAD_FEEDER_TAG_EN
    return t;
`else
    return t & 8'h00;
`endif
  endfunction

  task automatic offer(input int unsigned t, input logic [159:0] d);
    in_valid = 1'b1;
    in_tag   = TAG_W'(t);
    in_data  = d;
    check_eq($sformatf("ready_t%0h", t), in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned k;
    int unsigned bad;
    int unsigned blocked;
    logic [31:0] basic_words [5];
    logic [31:0] fw[$];

    basic_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_pa", phase_advance, 1'b0);
    check_eq("rst_din", din, 32'h0);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_res_tag", res_tag, 8'h00);
    check_eq("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("first_pa", phase_advance, 1'b1);

    // Basic emission
    offer(8'h01, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555});
    wait_pa(40, n);
    check_eq("basic_pa_latency", n, 19);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i >= 2 && i <= 6) check_eq($sformatf("basic_din%0d", i - 2), din, basic_words[i - 2]);
      else check_eq($sformatf("basic_din_idle%0d", i), din, 32'h0);
    end
    k = 7;
    while (!res_valid && k <= 100) begin
      step();
      k++;
    end
    check_eq("basic_res_latency", k, 85);
    check_eq("basic_res_tag", res_tag, etag(8'h01));

    // Idle
    clr();
    repeat (200) step();
    check_eq("idle_pa_count", pa_cyc.size(), 10);
    bad = 0;
    for (int i = 1; i < pa_cyc.size(); i++) if (pa_cyc[i] - pa_cyc[i - 1] != 20) bad++;
    check_eq("idle_pa_spacing", bad, 0);
    check_eq("idle_din_zero", din_nz, 0);
    check_eq("idle_no_res", res_cyc.size(), 0);

    // Back-pressure
    clr();
    blocked = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(i);
      in_data  = mk_msg(i);
      for (int w = 0; w < 100 && !in_ready; w++) begin
        blocked++;
        step();
      end
      step();
    end
    in_valid = 1'b0;
    repeat (330) step();
    check_eq("bp_ready_drop", blocked != 0, 1'b1);
    check_eq("bp_res_count", res_cyc.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < res_tags.size()) check_eq($sformatf("bp_tag%0d", i), res_tags[i], etag(8'(i)));
    end
    bad = 0;
    for (int i = 1; i < res_cyc.size(); i++) if (res_cyc[i] - res_cyc[i - 1] != 20) bad++;
    check_eq("bp_res_spacing", bad, 0);
    fw.delete();
    foreach (first_words[i]) if (first_words[i] != '0) fw.push_back(first_words[i]);
    check_eq("bp_issue_count", fw.size(), 10);
    bad = 0;
    foreach (fw[i]) if (fw[i] != wd(i, 0)) bad++;
    check_eq("bp_issue_order", bad, 0);

    // Mixed traffic: message and bubble slots alternate
    clr();
    for (int m = 0; m < 5; m++) begin
      wait_pa(40, n);
      offer(8'h20 + m, mk_msg(8'h20 + m));
      wait_pa(40, n);
    end
    repeat (100) step();
    check_eq("mix_res_count", res_cyc.size(), 5);
    bad = 0;
    for (int i = 1; i < res_cyc.size(); i++) if (res_cyc[i] - res_cyc[i - 1] != 40) bad++;
    check_eq("mix_res_spacing", bad, 0);
    bad = 0;
    foreach (res_tags[i]) if (res_tags[i] != etag(8'h20 + 8'(i))) bad++;
    check_eq("mix_tag_order", bad, 0);

    // Reset in the middle of a burst, with one more message buffered
    wait_pa(40, n);
    offer(8'h55, mk_msg(8'h55));
    wait_pa(40, n);
    offer(8'h66, mk_msg(8'h66));
    repeat (3) step();
    check_eq("mid_din_word2", din, wd(8'h55, 2));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_din_async", din, 32'h0);
    check_eq("mid_rst_ready", in_ready, 1'b0);
    step();
    check_eq("mid_rst_din_edge", din, 32'h0);
    rst_n = 1'b1;
    clr();
    step();
    check_eq("mid_first_pa", phase_advance, 1'b1);
    repeat (150) step();
    check_eq("mid_no_stale_res", res_cyc.size(), 0);
    bad = 0;
    foreach (first_words[i]) if (first_words[i] != '0) bad++;
    check_eq("mid_no_stale_issue", bad, 0);

`ifndef QUAD_FEEDER_TAG_EN
    check_eq("untagged_res_tag_zero", tag_nz, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
